// File: rtl/snoop_pkg.sv
// snoop_pkg: snoop type encodings, CR response bit positions and responder FSM states.
package snoop_pkg;
  typedef logic [3:0] acsnoop_t;
  localparam acsnoop_t READ_ONCE             = 4'b0000;
  localparam acsnoop_t READ_SHARED           = 4'b0001;
  localparam acsnoop_t READ_CLEAN            = 4'b0010;
  localparam acsnoop_t READ_NOT_SHARED_DIRTY = 4'b0011;
  localparam acsnoop_t READ_UNIQUE           = 4'b0111;
  localparam acsnoop_t CLEAN_SHARED          = 4'b1000;
  localparam acsnoop_t CLEAN_INVALID         = 4'b1001;
  localparam acsnoop_t MAKE_INVALID          = 4'b1101;
  localparam int RESP_DT  = 0;
  localparam int RESP_ERR = 1;
  localparam int RESP_PD  = 2;
  localparam int RESP_IS  = 3;
  localparam int RESP_WU  = 4;
  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WAIT, S_RESP, S_DATA, S_UPD} state_t;
endpackage

// File: rtl/snoop_resp_policy.sv
// snoop_resp_policy: maps snoop type and cached line state to CR response and line-state update.
module snoop_resp_policy
  import snoop_pkg::*;
(
  input  acsnoop_t   acsnoop_i,
  input  logic       hit_i,
  input  logic       dirty_i,
  input  logic       unique_i,
  output logic [4:0] resp_o,
  output logic       need_data_o,
  output logic       upd_inval_o,
  output logic       upd_clean_shared_o
);
  always_comb begin
    resp_o = '0;
    upd_inval_o = 1'b0;
    upd_clean_shared_o = 1'b0;
    case (acsnoop_i)
      READ_ONCE: if (hit_i) begin
        resp_o[RESP_DT] = 1'b1;
        resp_o[RESP_IS] = 1'b1;
        resp_o[RESP_WU] = unique_i;
      end
      READ_SHARED, READ_CLEAN, READ_NOT_SHARED_DIRTY: if (hit_i) begin
        resp_o[RESP_DT] = 1'b1;
        resp_o[RESP_IS] = 1'b1;
        resp_o[RESP_WU] = unique_i;
        resp_o[RESP_PD] = dirty_i;
        upd_clean_shared_o = 1'b1;
      end
      READ_UNIQUE: if (hit_i) begin
        resp_o[RESP_DT] = 1'b1;
        resp_o[RESP_WU] = unique_i;
        resp_o[RESP_PD] = dirty_i;
        upd_inval_o = 1'b1;
      end
      CLEAN_SHARED: if (hit_i) begin
        resp_o[RESP_DT] = dirty_i;
        resp_o[RESP_PD] = dirty_i;
        resp_o[RESP_IS] = 1'b1;
        upd_clean_shared_o = dirty_i;
      end
      CLEAN_INVALID: if (hit_i) begin
        resp_o[RESP_DT] = dirty_i;
        resp_o[RESP_PD] = dirty_i;
        upd_inval_o = 1'b1;
      end
      MAKE_INVALID: if (hit_i) begin
        resp_o[RESP_WU] = unique_i;
        upd_inval_o = 1'b1;
      end
      default: resp_o[RESP_ERR] = 1'b1;
    endcase
    need_data_o = resp_o[RESP_DT];
  end
endmodule

// File: rtl/snoop_responder.sv
// snoop_responder: cache-side snoop endpoint (AC -> lookup -> CR -> CD -> state update).
// Define SNOOP_RESPONDER_STATS_EN to build the saturating hit/miss counters.
module snoop_responder
  import snoop_pkg::*;
#(
  parameter int SNOOP_ADDR_WIDTH = 64,
  parameter int SNOOP_DATA_WIDTH = 64,
  parameter int CACHELINE_BYTES  = 64,
  localparam int BEATS = CACHELINE_BYTES * 8 / SNOOP_DATA_WIDTH,
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [SNOOP_ADDR_WIDTH-1:0] ac_addr_i,
  input  logic [2:0]                  ac_acprot_i,
  input  logic [3:0]                  ac_acsnoop_i,
  input  logic                        ac_valid_i,
  output logic                        ac_ready_o,
  output logic [4:0]                  cr_resp_o,
  output logic                        cr_valid_o,
  input  logic                        cr_ready_i,
  output logic [SNOOP_DATA_WIDTH-1:0] cd_data_o,
  output logic                        cd_last_o,
  output logic                        cd_valid_o,
  input  logic                        cd_ready_i,
  output logic                        lu_req_o,
  input  logic                        lu_gnt_i,
  output logic [SNOOP_ADDR_WIDTH-1:0] lu_addr_o,
  input  logic                        lu_valid_i,
  input  logic                        lu_hit_i,
  input  logic                        lu_dirty_i,
  input  logic                        lu_unique_i,
  output logic                        rd_req_o,
  output logic [BW-1:0]               rd_beat_o,
  input  logic [SNOOP_DATA_WIDTH-1:0] rd_data_i,
  output logic                        upd_valid_o,
  input  logic                        upd_ready_i,
  output logic                        upd_inval_o,
  output logic                        upd_clean_shared_o,
  output logic [31:0]                 hit_cnt_o,
  output logic [31:0]                 miss_cnt_o
);
  state_t state_q, state_d;
  logic [SNOOP_ADDR_WIDTH-1:0] addr_q, addr_d;
  acsnoop_t snoop_q, snoop_d;
  logic [2:0] acprot_unused_q, acprot_unused_d;
  logic [4:0] resp_q, resp_d, pol_resp;
  logic data_q, data_d, inval_q, inval_d, clean_q, clean_d;
  logic pol_data, pol_inval, pol_clean;
  logic [BW-1:0] beat_q, beat_d;
  logic rd_done_q, rd_done_d, infl_q, infl_d, infl_last_q, infl_last_d;
  logic cd_valid_q, cd_valid_d, cd_last_q, cd_last_d;
  logic [SNOOP_DATA_WIDTH-1:0] cd_data_q, cd_data_d, skid_data_q, skid_data_d;
  logic skid_v_q, skid_v_d, skid_last_q, skid_last_d;
  logic hs;
  logic [1:0] occ;

  snoop_resp_policy u_policy (
    .acsnoop_i(snoop_q), .hit_i(lu_hit_i), .dirty_i(lu_dirty_i), .unique_i(lu_unique_i),
    .resp_o(pol_resp), .need_data_o(pol_data), .upd_inval_o(pol_inval),
    .upd_clean_shared_o(pol_clean)
  );

  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    snoop_d = snoop_q;
    acprot_unused_d = acprot_unused_q;
    resp_d = resp_q;
    data_d = data_q;
    inval_d = inval_q;
    clean_d = clean_q;
    cd_valid_d = cd_valid_q;
    cd_last_d = cd_last_q;
    cd_data_d = cd_data_q;
    skid_v_d = skid_v_q;
    skid_last_d = skid_last_q;
    skid_data_d = skid_data_q;
    hs = cd_valid_q & cd_ready_i;
    // Reads are issued ahead so a one-entry skid keeps 1 beat/cycle without dropping returns on stall.
    occ = {1'b0, cd_valid_q} + {1'b0, skid_v_q} + {1'b0, infl_q} - {1'b0, hs};
    rd_req_o = state_q == S_DATA && !rd_done_q && occ < 2'd2;
    infl_d = rd_req_o;
    infl_last_d = rd_req_o && beat_q == BW'(BEATS - 1);
    rd_done_d = state_q == S_DATA && (rd_done_q | infl_last_d);
    beat_d = state_q != S_DATA ? '0 : rd_req_o ? beat_q + BW'(1) : beat_q;
    if (!cd_valid_q || hs) begin
      cd_valid_d = skid_v_q | infl_q;
      if (skid_v_q) begin
        cd_data_d = skid_data_q;
        cd_last_d = skid_last_q;
        skid_v_d = infl_q;
        skid_data_d = rd_data_i;
        skid_last_d = infl_last_q;
      end else if (infl_q) begin
        cd_data_d = rd_data_i;
        cd_last_d = infl_last_q;
      end
    end else if (infl_q) begin
      skid_v_d = 1'b1;
      skid_data_d = rd_data_i;
      skid_last_d = infl_last_q;
    end
    case (state_q)
      S_IDLE: if (ac_valid_i) begin
        addr_d = ac_addr_i;
        snoop_d = ac_acsnoop_i;
        acprot_unused_d = ac_acprot_i;
        state_d = S_LOOKUP;
      end
      S_LOOKUP: state_d = lu_gnt_i ? S_WAIT : S_LOOKUP;
      S_WAIT: if (lu_valid_i) begin
        resp_d = pol_resp;
        data_d = pol_data;
        inval_d = pol_inval;
        clean_d = pol_clean;
        state_d = S_RESP;
      end
      S_RESP: if (cr_ready_i) state_d = data_q ? S_DATA : (inval_q | clean_q) ? S_UPD : S_IDLE;
      S_DATA: if (hs && cd_last_q) state_d = (inval_q | clean_q) ? S_UPD : S_IDLE;
      S_UPD: state_d = upd_ready_i ? S_IDLE : S_UPD;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      snoop_q <= '0;
      acprot_unused_q <= '0;
      resp_q <= '0;
      data_q <= 1'b0;
      inval_q <= 1'b0;
      clean_q <= 1'b0;
      beat_q <= '0;
      rd_done_q <= 1'b0;
      infl_q <= 1'b0;
      infl_last_q <= 1'b0;
      cd_valid_q <= 1'b0;
      cd_last_q <= 1'b0;
      cd_data_q <= '0;
      skid_v_q <= 1'b0;
      skid_last_q <= 1'b0;
      skid_data_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      snoop_q <= snoop_d;
      acprot_unused_q <= acprot_unused_d;
      resp_q <= resp_d;
      data_q <= data_d;
      inval_q <= inval_d;
      clean_q <= clean_d;
      beat_q <= beat_d;
      rd_done_q <= rd_done_d;
      infl_q <= infl_d;
      infl_last_q <= infl_last_d;
      cd_valid_q <= cd_valid_d;
      cd_last_q <= cd_last_d;
      cd_data_q <= cd_data_d;
      skid_v_q <= skid_v_d;
      skid_last_q <= skid_last_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign ac_ready_o = state_q == S_IDLE;
  assign lu_req_o = state_q == S_LOOKUP;
  assign lu_addr_o = addr_q & ~SNOOP_ADDR_WIDTH'(CACHELINE_BYTES - 1);
  assign cr_valid_o = state_q == S_RESP;
  assign cr_resp_o = resp_q;
  assign cd_valid_o = cd_valid_q;
  assign cd_data_o = cd_data_q;
  assign cd_last_o = cd_last_q;
  assign rd_beat_o = beat_q;
  assign upd_valid_o = state_q == S_UPD;
  assign upd_inval_o = upd_valid_o & inval_q;
  assign upd_clean_shared_o = upd_valid_o & clean_q;

`ifdef SNOOP_RESPONDER_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic cnt_en;
  always_comb begin
    cnt_en = state_q == S_WAIT && lu_valid_i && !pol_resp[RESP_ERR];
    hit_cnt_d = hit_cnt_q + 32'(cnt_en && lu_hit_i && hit_cnt_q != '1);
    miss_cnt_d = miss_cnt_q + 32'(cnt_en && !lu_hit_i && miss_cnt_q != '1);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end
  assign hit_cnt_o = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  assign hit_cnt_o = '0;
  assign miss_cnt_o = '0;
`endif
endmodule

// File: tb/tb_snoop_responder.sv
// tb_snoop_responder: randomized self-checking bench against a rule-level snoop response model.
module tb_snoop_responder;
  logic clk = 0;
  logic rst_i = 1;
  logic [63:0] ac_addr_i = '0;
  logic [2:0] ac_acprot_i = '0;
  logic [3:0] ac_acsnoop_i = '0;
  logic ac_valid_i = 0, ac_ready_o;
  logic [4:0] cr_resp_o;
  logic cr_valid_o, cr_ready_i = 0;
  logic [63:0] cd_data_o;
  logic cd_last_o, cd_valid_o, cd_ready_i = 0;
  logic lu_req_o, lu_gnt_i = 0;
  logic [63:0] lu_addr_o;
  logic lu_valid_i = 0, lu_hit_i = 0, lu_dirty_i = 0, lu_unique_i = 0;
  logic rd_req_o;
  logic [2:0] rd_beat_o;
  logic [63:0] rd_data_i = '0;
  logic upd_valid_o, upd_ready_i = 0, upd_inval_o, upd_clean_shared_o;
  logic [31:0] hit_cnt_o, miss_cnt_o;

  localparam bit STATS =
`ifdef SNOOP_RESPONDER_STATS_EN
    1'b1;
`else
    1'b0;
`endif

  int tests = 0, fails = 0;
  int exp_hit = 0, exp_miss = 0;
  logic [63:0] line [8];

  typedef struct {
    logic [4:0] resp; int nbeats; logic [63:0] beat [8]; logic [7:0] last;
    int unstable; int span; bit upd; bit inval; bit clean; logic [63:0] lu_addr;
    bit timeout; bit ac_ready_end; bit rst_done; logic [2:0] post; int leak;
  } obs_t;

  snoop_responder dut (
    .clk_i(clk), .rst_i(rst_i),
    .ac_addr_i(ac_addr_i), .ac_acprot_i(ac_acprot_i), .ac_acsnoop_i(ac_acsnoop_i),
    .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o),
    .cr_resp_o(cr_resp_o), .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i),
    .cd_data_o(cd_data_o), .cd_last_o(cd_last_o), .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i),
    .lu_req_o(lu_req_o), .lu_gnt_i(lu_gnt_i), .lu_addr_o(lu_addr_o), .lu_valid_i(lu_valid_i),
    .lu_hit_i(lu_hit_i), .lu_dirty_i(lu_dirty_i), .lu_unique_i(lu_unique_i),
    .rd_req_o(rd_req_o), .rd_beat_o(rd_beat_o), .rd_data_i(rd_data_i),
    .upd_valid_o(upd_valid_o), .upd_ready_i(upd_ready_i), .upd_inval_o(upd_inval_o),
    .upd_clean_shared_o(upd_clean_shared_o), .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk = ~clk;

  // Line storage: answers each beat read exactly one cycle later, garbage otherwise.
  always @(posedge clk) rd_data_i <= rd_req_o ? line[rd_beat_o] : {$urandom, $urandom};

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1);
  end

  function automatic bit valid_type(input logic [3:0] s);
    return s inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9, 4'd13};
  endfunction

  // Returns {inval, clean_shared, resp[4:0]}; data is needed when resp[0] is set.
  function automatic logic [6:0] ref_policy(input logic [3:0] s, input bit h, d, u);
    bit dt, pd, is, wu, inv, cln;
    if (!valid_type(s)) return 7'b00_00010;
    if (!h) return '0;
    dt = s inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd7} || (s inside {4'd8, 4'd9} && d);
    pd = d && s != 4'd0 && s != 4'd13;
    is = s inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd8};
    wu = u && s inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd13};
    inv = s inside {4'd7, 4'd9, 4'd13};
    cln = s inside {4'd1, 4'd2, 4'd3} || (s == 4'd8 && d);
    return {inv, cln, wu, is, pd, 1'b0, dt};
  endfunction

  task automatic apply_reset();
    rst_i = 1;
    repeat (2) @(negedge clk);
    rst_i = 0;
    exp_hit = 0;
    exp_miss = 0;
  endtask

  task automatic do_snoop(input logic [63:0] a, input logic [3:0] s, input bit h, d, u,
                          input int mode, input int rst_beat, output obs_t o);
    int cyc, first;
    bit prev_stall;
    logic [63:0] prev_d;
    logic prev_l;
    o.resp = '0; o.nbeats = 0; o.last = '0; o.unstable = 0; o.span = 0; o.upd = 0;
    o.inval = 0; o.clean = 0; o.lu_addr = '0; o.timeout = 0; o.ac_ready_end = 0;
    o.rst_done = 0; o.post = '0; o.leak = 0;
    for (int i = 0; i < 8; i++) o.beat[i] = '0;
    first = 0; prev_stall = 0; prev_d = '0; prev_l = 0;
    for (int i = 0; i < 8; i++) line[i] = {$urandom, $urandom};
    @(negedge clk);
    ac_valid_i = 1; ac_addr_i = a; ac_acsnoop_i = s; ac_acprot_i = 3'($urandom);
    cyc = 0;
    while (!ac_ready_o && cyc < 20) begin @(negedge clk); cyc++; end
    @(negedge clk);
    ac_valid_i = 0; ac_addr_i = {$urandom, $urandom};
    o.lu_addr = lu_req_o ? lu_addr_o : '1;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    lu_gnt_i = 1;
    @(negedge clk);
    lu_gnt_i = 0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    lu_valid_i = 1; lu_hit_i = h; lu_dirty_i = d; lu_unique_i = u;
    @(negedge clk);
    lu_valid_i = 0; lu_hit_i = 1'($urandom); lu_dirty_i = 1'($urandom); lu_unique_i = 1'($urandom);
    cyc = 0;
    while (!cr_valid_o && cyc < 20) begin @(negedge clk); cyc++; end
    if (cyc == 20) o.timeout = 1;
    o.resp = cr_resp_o;
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      if (!cr_valid_o || cr_resp_o !== o.resp) o.unstable++;
    end
    cr_ready_i = 1;
    @(negedge clk);
    cr_ready_i = 0;
    for (cyc = 0; cyc < 100; cyc++) begin
      if (ac_ready_o) begin o.ac_ready_end = 1; break; end
      cd_ready_i = mode == 0 ? 1'b1 : mode == 1 ? cyc[0] : 1'($urandom);
      upd_ready_i = $urandom_range(0, 2) != 0;
      if (upd_valid_o) begin o.upd = 1; o.inval = upd_inval_o; o.clean = upd_clean_shared_o; end
      if (cd_valid_o) begin
        if (rst_beat >= 0 && o.nbeats == rst_beat) begin
          rst_i = 1;
          @(negedge clk);
          rst_i = 0;
          o.rst_done = 1;
          o.post = {cd_valid_o, upd_valid_o, ac_ready_o};
          repeat (5) begin @(negedge clk); if (cd_valid_o || upd_valid_o) o.leak++; end
          break;
        end
        if (prev_stall && (cd_data_o !== prev_d || cd_last_o !== prev_l)) o.unstable++;
        if (cd_ready_i) begin
          if (o.nbeats < 8) begin o.beat[o.nbeats] = cd_data_o; o.last[o.nbeats] = cd_last_o; end
          if (o.nbeats == 0) first = cyc;
          o.span = cyc - first + 1;
          o.nbeats++;
        end
        prev_stall = !cd_ready_i; prev_d = cd_data_o; prev_l = cd_last_o;
      end else prev_stall = 0;
      @(negedge clk);
    end
    if (!o.ac_ready_end && !o.rst_done) o.timeout = 1;
    cd_ready_i = 0;
    upd_ready_i = 0;
    if (valid_type(s)) begin if (h) exp_hit++; else exp_miss++; end
  endtask

  function automatic int beat_errs(input obs_t o);
    int n = 0;
    for (int i = 0; i < 8; i++) if (o.beat[i] !== line[i]) n++;
    return n;
  endfunction

  task automatic test_reset();
    apply_reset();
    tests++;
    if ({ac_ready_o, lu_req_o, cr_valid_o, cd_valid_o, rd_req_o, upd_valid_o, cd_last_o} !== 7'b1000000) begin
      fails++; $display("FAIL reset_ctrl: got %b want 1000000", {ac_ready_o, lu_req_o, cr_valid_o, cd_valid_o, rd_req_o, upd_valid_o, cd_last_o});
    end
    tests++;
    if (cr_resp_o !== 5'b0 || cd_data_o !== 64'b0) begin
      fails++; $display("FAIL reset_data: resp %b data %h want 0", cr_resp_o, cd_data_o);
    end
    tests++;
    if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0) begin
      fails++; $display("FAIL reset_cnt: hit %0d miss %0d want 0", hit_cnt_o, miss_cnt_o);
    end
  endtask

  task automatic test_miss();
    obs_t o;
    do_snoop(64'h1000_0038, 4'b0001, 0, 1, 1, 0, -1, o);
    tests++;
    if (o.lu_addr !== 64'h1000_0000) begin fails++; $display("FAIL miss_lu_addr: got %h want 1000_0000", o.lu_addr); end
    tests++;
    if (o.resp !== 5'b00000) begin fails++; $display("FAIL miss_resp: got %b want 00000", o.resp); end
    tests++;
    if (o.nbeats != 0 || o.upd) begin fails++; $display("FAIL miss_no_cd_upd: beats %0d upd %0b want 0 0", o.nbeats, o.upd); end
    tests++;
    if (!o.ac_ready_end || o.timeout) begin fails++; $display("FAIL miss_ac_ready: ready %0b timeout %0b want 1 0", o.ac_ready_end, o.timeout); end
  endtask

  task automatic test_read_unique();
    obs_t o;
    do_snoop({$urandom, $urandom}, 4'b0111, 1, 1, 1, 0, -1, o);
    tests++;
    if (o.resp !== 5'b10101) begin fails++; $display("FAIL ru_resp: got %b want 10101", o.resp); end
    tests++;
    if (o.nbeats != 8 || beat_errs(o) != 0) begin fails++; $display("FAIL ru_beats: count %0d bad %0d want 8 0", o.nbeats, beat_errs(o)); end
    tests++;
    if (o.last !== 8'h80) begin fails++; $display("FAIL ru_last: got %b want 10000000", o.last); end
    tests++;
    if (o.span != 8) begin fails++; $display("FAIL ru_back_to_back: span %0d cycles want 8", o.span); end
    tests++;
    if ({o.upd, o.inval, o.clean} !== 3'b110) begin fails++; $display("FAIL ru_upd: got %b want 110", {o.upd, o.inval, o.clean}); end
  endtask

  task automatic test_read_shared_stall();
    obs_t o;
    do_snoop({$urandom, $urandom}, 4'b0001, 1, 0, 0, 1, -1, o);
    tests++;
    if (o.resp !== 5'b01001) begin fails++; $display("FAIL rs_resp: got %b want 01001", o.resp); end
    tests++;
    if (o.nbeats != 8 || beat_errs(o) != 0 || o.last !== 8'h80) begin
      fails++; $display("FAIL rs_beats: count %0d bad %0d last %b want 8 0 10000000", o.nbeats, beat_errs(o), o.last);
    end
    tests++;
    if (o.unstable != 0) begin fails++; $display("FAIL rs_stall_stable: %0d changes want 0", o.unstable); end
    tests++;
    if ({o.upd, o.inval, o.clean} !== 3'b101) begin fails++; $display("FAIL rs_upd: got %b want 101", {o.upd, o.inval, o.clean}); end
  endtask

  task automatic test_error();
    obs_t o;
    do_snoop({$urandom, $urandom}, 4'b0101, 1, 1, 1, 0, -1, o);
    tests++;
    if (o.resp !== 5'b00010) begin fails++; $display("FAIL err_resp: got %b want 00010", o.resp); end
    tests++;
    if (o.nbeats != 0 || o.upd || !o.ac_ready_end) begin
      fails++; $display("FAIL err_no_cd_upd: beats %0d upd %0b idle %0b want 0 0 1", o.nbeats, o.upd, o.ac_ready_end);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    logic [6:0] e;
    do_snoop({$urandom, $urandom}, 4'b0111, 1, 1, 1, 0, 3, o);
    exp_hit = 0;
    exp_miss = 0;
    tests++;
    if (!o.rst_done || o.post !== 3'b001) begin fails++; $display("FAIL rst_mid_state: done %0b cdv/updv/acr %b want 1 001", o.rst_done, o.post); end
    tests++;
    if (o.leak != 0) begin fails++; $display("FAIL rst_mid_leak: %0d valid cycles want 0", o.leak); end
    e = ref_policy(4'b0000, 1, 0, 1);
    do_snoop({$urandom, $urandom}, 4'b0000, 1, 0, 1, 2, -1, o);
    tests++;
    if (o.resp !== e[4:0] || o.nbeats != 8 || beat_errs(o) != 0 || o.upd) begin
      fails++; $display("FAIL rst_mid_next: resp %b beats %0d bad %0d upd %0b want %b 8 0 0", o.resp, o.nbeats, beat_errs(o), o.upd, e[4:0]);
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic [6:0] e;
    logic [3:0] s;
    bit h, d, u, eu;
    int mode;
    for (int n = 0; n < 30; n++) begin
      s = 4'($urandom); h = 1'($urandom); d = 1'($urandom); u = 1'($urandom);
      mode = $urandom_range(0, 2);
      e = ref_policy(s, h, d, u);
      eu = e[6] | e[5];
      do_snoop({$urandom, $urandom}, s, h, d, u, mode, -1, o);
      tests++;
      if (o.resp !== e[4:0]) begin fails++; $display("FAIL rand_resp[%0d]: snoop %b hdu %b%b%b got %b want %b", n, s, h, d, u, o.resp, e[4:0]); end
      tests++;
      if (o.nbeats != (e[0] ? 8 : 0)) begin fails++; $display("FAIL rand_nbeats[%0d]: got %0d want %0d", n, o.nbeats, e[0] ? 8 : 0); end
      if (e[0]) begin
        tests++;
        if (beat_errs(o) != 0 || o.last !== 8'h80) begin fails++; $display("FAIL rand_data[%0d]: bad %0d last %b", n, beat_errs(o), o.last); end
        if (mode == 0) begin
          tests++;
          if (o.span != 8) begin fails++; $display("FAIL rand_span[%0d]: got %0d want 8", n, o.span); end
        end
      end
      tests++;
      if ({o.upd, o.inval, o.clean} !== {eu, e[6], e[5]}) begin
        fails++; $display("FAIL rand_upd[%0d]: got %b want %b", n, {o.upd, o.inval, o.clean}, {eu, e[6], e[5]});
      end
      tests++;
      if (o.unstable != 0 || o.timeout || o.lu_addr !== {ac_addr_q_dummy(o.lu_addr)}) begin
        fails++; $display("FAIL rand_proto[%0d]: unstable %0d timeout %0b lu_addr %h", n, o.unstable, o.timeout, o.lu_addr);
      end
    end
    tests++;
    if (hit_cnt_o !== (STATS ? 32'(exp_hit) : 32'd0) || miss_cnt_o !== (STATS ? 32'(exp_miss) : 32'd0)) begin
      fails++; $display("FAIL rand_stats: hit %0d miss %0d want model %0d %0d (stats %0b)", hit_cnt_o, miss_cnt_o, exp_hit, exp_miss, STATS);
    end
  endtask

  // A line-aligned lookup address has its low six bits clear.
  function automatic logic [63:0] ac_addr_q_dummy(input logic [63:0] a);
    return {a[63:6], 6'b0};
  endfunction

  task automatic test_stats();
    obs_t o;
    logic [3:0] types [5];
    bit hits [5];
    types = '{4'b0001, 4'b0111, 4'b1000, 4'b1101, 4'b0000};
    hits = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    apply_reset();
    for (int i = 0; i < 5; i++) do_snoop({$urandom, $urandom}, types[i], hits[i], 1'($urandom), 1'($urandom), 0, -1, o);
    do_snoop({$urandom, $urandom}, 4'b1111, 1, 1, 1, 0, -1, o);
    tests++;
    if (hit_cnt_o !== (STATS ? 32'd3 : 32'd0)) begin fails++; $display("FAIL stats_hit: got %0d want %0d", hit_cnt_o, STATS ? 3 : 0); end
    tests++;
    if (miss_cnt_o !== (STATS ? 32'd2 : 32'd0)) begin fails++; $display("FAIL stats_miss: got %0d want %0d", miss_cnt_o, STATS ? 2 : 0); end
  endtask

  initial begin
    test_reset();
    test_miss();
    test_read_unique();
    test_read_shared_stall();
    test_error();
    test_reset_mid();
    test_random();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
